// File: rtl/fetch_prefetch_unit_if.sv
// APB bus bundle shared by the instruction-memory master and its slave.
interface apb_if #(
    parameter int ADDR_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: APB read master, prefetch queue, static JAL/branch predict.
// Define FETCH_BTFN_PRED_EN to follow backward conditional branches.
module apb_controller_sbm #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              error,
    output logic [31:0]       rdata,
    apb_if.master             apb
);
    typedef enum logic [1:0] {C_IDLE, C_SETUP, C_ACCESS} cst_t;

    cst_t              st_q, st_d;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= C_IDLE;
            addr_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_q == C_IDLE && start) addr_q <= addr;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            C_IDLE:   if (start) st_d = C_SETUP;
            C_SETUP:  st_d = C_ACCESS;
            C_ACCESS: if (apb.pready) st_d = C_IDLE;
            default:  st_d = C_IDLE;
        endcase
    end

    assign apb.psel    = (st_q != C_IDLE);
    assign apb.penable = (st_q == C_ACCESS);
    assign apb.pwrite  = 1'b0;
    assign apb.paddr   = addr_q;
    assign apb.pwdata  = '0;
    assign valid = (st_q == C_ACCESS) && apb.pready && !apb.pslverr;
    assign error = (st_q == C_ACCESS) && apb.pready && apb.pslverr;
    assign rdata = apb.prdata;
endmodule

module fetch_prefetch_unit #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] INIT_PC = '0,
    parameter int                DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    apb_if.master                    imem_apb,
    input  logic                     redirect_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [31:0]              inst_o,
    output logic                     pred_taken_o,
    output logic                     fault_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_DISCARD, ST_HALT} st_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
        logic              pred;
        logic              fault;
    } entry_t;

    entry_t            q [DEPTH];
    logic [PTR_W-1:0]  rd_q, wr_q;
    logic [CNT_W-1:0]  count_q;
    st_t               st_q, st_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;

    logic              start, apb_valid, apb_error, resp;
    logic [31:0]       rdata;
    logic              push, pop, room, inflight;
    entry_t            push_e;
    logic [ADDR_W-1:0] nxt_pc;
    logic              nxt_pred;
    logic [CNT_W:0]    occ;

    apb_controller_sbm #(.ADDR_W(ADDR_W)) u_apb (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .addr  (fpc_q),
        .valid (apb_valid),
        .error (apb_error),
        .rdata (rdata),
        .apb   (imem_apb)
    );

    assign resp = apb_valid | apb_error;

    // Static prediction from the returned word
    logic              is_jal, is_bwd_br;
    logic [20:0]       j_imm;
    logic [12:0]       b_imm;

    assign is_jal    = (rdata[6:0] == 7'b1101111);
    assign is_bwd_br = (rdata[6:0] == 7'b1100011) && rdata[31];
    assign j_imm = {rdata[31], rdata[19:12], rdata[20], rdata[30:21], 1'b0};
    assign b_imm = {rdata[31], rdata[7], rdata[30:25], rdata[11:8], 1'b0};

    always_comb begin
        nxt_pc   = fpc_q + ADDR_W'(4);
        nxt_pred = 1'b0;
        unique case (1'b1)
            is_jal: begin
                nxt_pc   = fpc_q + {{(ADDR_W-21){j_imm[20]}}, j_imm};
                nxt_pred = 1'b1;
            end
`ifdef FETCH_BTFN_PRED_EN
            is_bwd_br: begin
                nxt_pc   = fpc_q + {{(ADDR_W-13){b_imm[12]}}, b_imm};
                nxt_pred = 1'b1;
            end
`else
            is_bwd_br: ;
`endif
            default: ;
        endcase
    end

    assign inflight = (st_q == ST_WAIT) || (st_q == ST_DISCARD);
    assign occ  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
    assign room = occ < (CNT_W+1)'(DEPTH);

    always_comb begin
        st_d   = st_q;
        fpc_d  = fpc_q;
        start  = 1'b0;
        push   = 1'b0;
        push_e = '{pc: fpc_q, inst: rdata, pred: nxt_pred, fault: 1'b0};
        if (redirect_i) begin
            fpc_d = redirect_pc_i;
            unique case (st_q)
                ST_WAIT:    st_d = resp ? ST_ISSUE : ST_DISCARD;
                ST_DISCARD: st_d = resp ? ST_ISSUE : ST_DISCARD;
                default:    st_d = ST_ISSUE;
            endcase
        end else begin
            unique case (st_q)
                ST_ISSUE: if (room) begin
                    start = 1'b1;
                    st_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (apb_valid) begin
                        push  = 1'b1;
                        fpc_d = nxt_pc;
                        st_d  = ST_ISSUE;
                    end else if (apb_error) begin
                        push   = 1'b1;
                        push_e = '{pc: fpc_q, inst: 32'h0, pred: 1'b0, fault: 1'b1};
                        st_d   = ST_HALT;
                    end
                end
                ST_DISCARD: if (resp) st_d = ST_ISSUE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_ISSUE;
            fpc_q <= INIT_PC;
        end else begin
            st_q  <= st_d;
            fpc_q <= fpc_d;
        end
    end

    assign pop = valid_o & ready_i & ~redirect_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (redirect_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                q[wr_q] <= push_e;
                wr_q    <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign valid_o      = (count_q != '0);
    assign pc_o         = q[rd_q].pc;
    assign inst_o       = q[rd_q].inst;
    assign pred_taken_o = q[rd_q].pred;
    assign fault_o      = q[rd_q].fault;
    assign level_o      = count_q;
endmodule
